fc_result_writer: RTL and testbench
===================================

FC_RESULT_WRITER -- requirements
Module: fc_result_writer

Interface
REQ-001 Parameters SHALL be: batch_size, default 10, number of result rows; bias_size, default 10, number of results per row; word_len, default 32, result word width; max_burst, default 16, beats per burst (range 1..16); id, default 4'h1, value driven on awuser_id.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous, active-low reset.
- init_addr, in, 28, byte base address of the result region.
- init_addr_en, in, 1, loads init_addr.
- result, in, batch_size*bias_size*word_len, flattened result array; word k sits at bits [k*32 +: 32].
- result_valid, in, 1, result array valid.
- result_ready, out, 1, block can accept a result array.
- awaddr, out, 28, burst start address.
- awlen, out, 4, beats minus one.
- awvalid, out, 1, address valid.
- awready, in, 1, address accepted.
- awuser_id, out, 4, transaction id.
- awuser_ap, out, 1, final-burst marker.
- wdata, out, 32, beat data.
- wstrb, out, 4, byte enables.
- wvalid, out, 1, beat valid.
- wready, in, 1, beat accepted.
- wlast, out, 1, last beat of burst.
- done, out, 1, one-cycle completion pulse.

Function
REQ-003 N = batch_size*bias_size SHALL be the word count; words SHALL be sent in index order 0..N-1.
REQ-004 States SHALL be IDLE, AW, W, DONE.
REQ-005 In IDLE, result_ready SHALL be 1. A result array is accepted when result_valid=1 and result_ready=1. On acceptance, the array SHALL be latched into an internal buffer, the word index SHALL be set to 0, and the state SHALL go to AW on the next cycle.
REQ-006 In AW, awvalid SHALL be 1 and awaddr = base + 4*word_index (28-bit wrap). Beat count = min(max_burst, N - word_index), and awlen = beat count - 1. The state SHALL move to W on the cycle awready=1 is sampled.
REQ-007 awaddr, awlen, awuser_id and awuser_ap SHALL remain stable while awvalid=1 and awready=0.
REQ-008 awuser_ap SHALL be 1 only for the burst that contains word N-1.
REQ-009 In W, wvalid SHALL be 1, wdata = buffer[word_index] and wstrb = 4'hF. A beat transfers when wready=1, and word_index then increments. wdata SHALL be held while wready=0.
REQ-010 wlast SHALL be 1 exactly on the final beat of each burst.
REQ-011 After the wlast beat transfers: if word_index = N, the state SHALL go to DONE; otherwise it SHALL return to AW.
REQ-012 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-013 Base address SHALL load from init_addr when init_addr_en=1 in IDLE. init_addr_en outside IDLE SHALL be ignored.
REQ-014 If init_addr_en and result_valid arrive in the same IDLE cycle, the new init_addr SHALL be used for that result.
REQ-015 result_ready SHALL be 0 outside IDLE. result_valid arriving then SHALL be ignored and SHALL NOT be queued.
REQ-016 Outputs SHALL never be X: wdata and awaddr SHALL read 0 when their valid signal is low.

Reset
REQ-017 On rst_n=0, asynchronously:
- state = IDLE, base = 0, word_index = 0, buffer cleared;
- awvalid, wvalid, wlast, done, awuser_ap = 0;
- awaddr, awlen, wdata, wstrb = 0;
- result_ready = 1 after release.
REQ-018 Reset mid-burst SHALL abandon the transfer; no done pulse SHALL be issued for it.

Structure
REQ-019 A shared package fc_pkg SHALL hold the state enum, ADDR_W=28, LEN_W=4, and the byte-per-word constant 4.
REQ-020 One sub-module, fc_burst_calc, SHALL compute beat count, awlen and the last-burst flag from word_index, N and max_burst.

Verification
REQ-021 Defaults, base 0x0000100, awready and wready held at 1:
- 7 bursts; awlen = 15 on six bursts, then 3;
- awaddr = 0x100, 0x140, ..., 0x280;
- awuser_ap=1 on burst 7 only;
- done pulses once.
REQ-022 wready toggling 1/0 every cycle: wdata held stable on stalled cycles, 100 beats delivered in order, 7 wlast pulses.
REQ-023 awready delayed 5 cycles on burst 2: awaddr and awlen held stable, no W beats issued early.
REQ-024 result_valid reasserted during burst 3: result_ready=0, the new data is not captured, the original 100 words complete.
REQ-025 rst_n low at beat 20: all outputs zero immediately, no done pulse; a fresh run afterwards completes correctly.
REQ-026 batch_size=1, bias_size=16: exactly one burst with awlen=15, awuser_ap=1.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types and constants for the fully-connected result writer.
package fc_pkg;

    localparam int unsigned ADDR_W         = 28;
    localparam int unsigned LEN_W          = 4;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        StIdle,
        StAw,
        StW,
        StDone
    } state_e;

endpackage

// File: rtl/fc_burst_calc.sv
// Burst sizing: beats left in the current burst, AXI-style length and final-burst flag.
module fc_burst_calc
    import fc_pkg::*;
#(
    parameter int unsigned n         = 100,
    parameter int unsigned max_burst = 16,
    parameter int unsigned idx_w     = 7
) (
    input  logic [idx_w-1:0] word_index,
    output logic [LEN_W:0]   beats,
    output logic [LEN_W-1:0] awlen,
    output logic             last_burst
);

    logic [31:0] remaining;
    logic [31:0] count;

    always_comb begin
        remaining  = n - 32'(word_index);
        count      = (remaining > max_burst) ? max_burst : remaining;
        beats      = (LEN_W + 1)'(count);
        awlen      = LEN_W'(count - 32'd1);
        last_burst = (remaining <= max_burst);
    end

endmodule

// File: rtl/fc_result_writer.sv
// Streams a latched result array out as a sequence of address/data bursts.
module fc_result_writer
    import fc_pkg::*;
#(
    parameter int unsigned batch_size = 10,
    parameter int unsigned bias_size  = 10,
    parameter int unsigned word_len   = 32,
    parameter int unsigned max_burst  = 16,
    parameter logic [3:0]  id         = 4'h1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [ADDR_W-1:0]                    init_addr,
    input  logic                                 init_addr_en,
    input  logic [batch_size*bias_size*word_len-1:0] result,
    input  logic                                 result_valid,
    output logic                                 result_ready,
    output logic [ADDR_W-1:0]                    awaddr,
    output logic [LEN_W-1:0]                     awlen,
    output logic                                 awvalid,
    input  logic                                 awready,
    output logic [3:0]                           awuser_id,
    output logic                                 awuser_ap,
    output logic [word_len-1:0]                  wdata,
    output logic [3:0]                           wstrb,
    output logic                                 wvalid,
    input  logic                                 wready,
    output logic                                 wlast,
    output logic                                 done
);

    localparam int unsigned N    = batch_size * bias_size;
    localparam int unsigned IdxW = $clog2(N + 1);

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       base_q, base_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [N*word_len-1:0]   buf_q, buf_d;
    logic [LEN_W:0]          beat_q, beat_d;

    logic [LEN_W:0]          calc_beats;
    logic [LEN_W-1:0]        calc_awlen;
    logic                    calc_last;

    fc_burst_calc #(
        .n         (N),
        .max_burst (max_burst),
        .idx_w     (IdxW)
    ) u_burst_calc (
        .word_index (idx_q),
        .beats      (calc_beats),
        .awlen      (calc_awlen),
        .last_burst (calc_last)
    );

    assign awuser_id = id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            base_q  <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        idx_d        = idx_q;
        buf_d        = buf_q;
        beat_d       = beat_q;
        result_ready = 1'b0;
        awvalid      = 1'b0;
        awaddr       = '0;
        awlen        = '0;
        awuser_ap    = 1'b0;
        wvalid       = 1'b0;
        wdata        = '0;
        wstrb        = 4'h0;
        wlast        = 1'b0;
        done         = 1'b0;

        unique case (state_q)
            StIdle: begin
                result_ready = 1'b1;
                if (init_addr_en) begin
                    base_d = init_addr;
                end
                if (result_valid) begin
                    buf_d   = result;
                    idx_d   = '0;
                    state_d = StAw;
                end
            end
            StAw: begin
                awvalid   = 1'b1;
                awaddr    = base_q + ADDR_W'(idx_q) * ADDR_W'(BYTES_PER_WORD);
                awlen     = calc_awlen;
                awuser_ap = calc_last;
                if (awready) begin
                    beat_d  = calc_beats;
                    state_d = StW;
                end
            end
            StW: begin
                wvalid = 1'b1;
                wdata  = buf_q[idx_q*word_len +: word_len];
                wstrb  = 4'hF;
                wlast  = (beat_q == (LEN_W + 1)'(1));
                if (wready) begin
                    idx_d  = idx_q + IdxW'(1);
                    beat_d = beat_q - (LEN_W + 1)'(1);
                    if (wlast) begin
                        state_d = ((32'(idx_q) + 32'd1) == N) ? StDone : StAw;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_fc_result_writer.sv
// Directed bench for fc_result_writer: default 100-word configuration plus a 16-word instance.
module tb_fc_result_writer;

    localparam int unsigned NW = 100;
    localparam int unsigned NS = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [27:0]      init_addr;
    logic             init_addr_en;
    logic [NW*32-1:0] result;
    logic             result_valid;
    logic             result_ready;
    logic [27:0]      awaddr;
    logic [3:0]       awlen;
    logic             awvalid;
    logic             awready;
    logic [3:0]       awuser_id;
    logic             awuser_ap;
    logic [31:0]      wdata;
    logic [3:0]       wstrb;
    logic             wvalid;
    logic             wready;
    logic             wlast;
    logic             done;

    logic [27:0]      s_init_addr;
    logic             s_init_addr_en;
    logic [NS*32-1:0] s_result;
    logic             s_result_valid;
    logic             s_result_ready;
    logic [27:0]      s_awaddr;
    logic [3:0]       s_awlen;
    logic             s_awvalid;
    logic             s_awready;
    logic [3:0]       s_awuser_id;
    logic             s_awuser_ap;
    logic [31:0]      s_wdata;
    logic [3:0]       s_wstrb;
    logic             s_wvalid;
    logic             s_wready;
    logic             s_wlast;
    logic             s_done;

    always #5 clk = ~clk;

    fc_result_writer dut (
        .clk(clk), .rst_n(rst_n), .init_addr(init_addr), .init_addr_en(init_addr_en),
        .result(result), .result_valid(result_valid), .result_ready(result_ready),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .awuser_id(awuser_id), .awuser_ap(awuser_ap), .wdata(wdata), .wstrb(wstrb),
        .wvalid(wvalid), .wready(wready), .wlast(wlast), .done(done)
    );

    fc_result_writer #(.batch_size(1), .bias_size(16)) dut_small (
        .clk(clk), .rst_n(rst_n), .init_addr(s_init_addr), .init_addr_en(s_init_addr_en),
        .result(s_result), .result_valid(s_result_valid), .result_ready(s_result_ready),
        .awaddr(s_awaddr), .awlen(s_awlen), .awvalid(s_awvalid), .awready(s_awready),
        .awuser_id(s_awuser_id), .awuser_ap(s_awuser_ap), .wdata(s_wdata), .wstrb(s_wstrb),
        .wvalid(s_wvalid), .wready(s_wready), .wlast(s_wlast), .done(s_done)
    );

    int tests = 0;
    int fails = 0;

    logic [27:0] aw_addr_q [$];
    logic [3:0]  aw_len_q  [$];
    logic        aw_ap_q   [$];
    logic [31:0] w_data_q  [$];
    int wlast_cnt, done_cnt, hold_err, zero_err, early_err, rr_err;

    bit wr_toggle;
    int aw_delay_burst;
    int aw_delay_left;
    bit inject_on;
    bit injected;
    bit busy_init_on;
    int stop_beats;

    function automatic logic [31:0] pat(int k, bit alt);
        if (alt) return 32'hBAD0_0000 + 32'(k);
        return 32'h5A00_0000 + 32'(k) * 32'h11;
    endfunction

    task automatic load_result(bit alt);
        for (int k = 0; k < NW; k++) result[k*32 +: 32] = pat(k, alt);
    endtask

    task automatic clear_rec();
        aw_addr_q.delete(); aw_len_q.delete(); aw_ap_q.delete(); w_data_q.delete();
        wlast_cnt = 0; done_cnt = 0; hold_err = 0; zero_err = 0; early_err = 0; rr_err = 0;
        wr_toggle = 0; aw_delay_burst = 0; aw_delay_left = 0;
        inject_on = 0; injected = 0; busy_init_on = 0; stop_beats = 0;
    endtask

    // Loads base and result in the same IDLE cycle, leaves the bench at a negedge in AW.
    task automatic start(logic [27:0] base, bit with_addr);
        @(negedge clk);
        load_result(1'b0);
        init_addr    = base;
        init_addr_en = with_addr;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        init_addr_en = 1'b0;
    endtask

    // Runs from the current negedge until done, stop_beats, or the cycle budget.
    task automatic run(int budget);
        logic        pwv = 0, pwr = 0, pav = 0, par = 0;
        logic [31:0] pwd = '0;
        logic [27:0] paa = '0;
        logic [3:0]  pal = '0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (pwv && !pwr && wvalid && wdata !== pwd) hold_err++;
            if (pav && !par && (!awvalid || awaddr !== paa || awlen !== pal)) hold_err++;
            if (!wvalid && wdata !== 32'h0) zero_err++;
            if (!awvalid && awaddr !== 28'h0) zero_err++;
            if (done) done_cnt++;
            wready = wr_toggle ? ~wready : 1'b1;
            if (awvalid && aw_addr_q.size() == aw_delay_burst - 1 && aw_delay_left > 0) begin
                awready = 1'b0;
                aw_delay_left--;
            end else begin
                awready = 1'b1;
            end
            if (inject_on && !injected && aw_addr_q.size() == 3) begin
                load_result(1'b1);
                result_valid = 1'b1;
                if (result_ready !== 1'b0) rr_err++;
            end
            if (inject_on && aw_addr_q.size() >= 4) begin
                result_valid = 1'b0;
                injected = 1;
            end
            if (busy_init_on) begin
                init_addr    = 28'hFFF_F000;
                init_addr_en = (aw_addr_q.size() == 1);
            end
            if (wvalid && w_data_q.size() >= aw_addr_q.size() * 16) early_err++;
            if (awvalid && awready) begin
                aw_addr_q.push_back(awaddr);
                aw_len_q.push_back(awlen);
                aw_ap_q.push_back(awuser_ap);
            end
            if (wvalid && wready) begin
                w_data_q.push_back(wdata);
                if (wlast) wlast_cnt++;
            end
            pwv = wvalid; pwr = wready; pav = awvalid; par = awready;
            pwd = wdata;  paa = awaddr; pal = awlen;
            if (done) break;
            if (stop_beats > 0 && w_data_q.size() >= stop_beats) break;
            @(negedge clk);
        end
        init_addr_en = 1'b0;
    endtask

    task automatic check_full_run(string tag, logic [27:0] base);
        int bad;
        tests++;
        if (done_cnt !== 1) begin
            fails++; $display("FAIL %s done_count: got %0d expected 1", tag, done_cnt);
        end
        tests++;
        if (aw_addr_q.size() !== 7) begin
            fails++; $display("FAIL %s bursts: got %0d expected 7", tag, aw_addr_q.size());
        end
        for (int b = 0; b < 7 && b < aw_addr_q.size(); b++) begin
            tests++;
            if (aw_addr_q[b] !== base + 28'(b) * 28'h40 ||
                aw_len_q[b] !== ((b < 6) ? 4'd15 : 4'd3) || aw_ap_q[b] !== (b == 6)) begin
                fails++;
                $display("FAIL %s burst%0d: got addr %h len %0d ap %0d", tag, b,
                         aw_addr_q[b], aw_len_q[b], aw_ap_q[b]);
            end
        end
        tests++;
        if (w_data_q.size() !== NW || wlast_cnt !== 7) begin
            fails++;
            $display("FAIL %s beats: got %0d beats %0d wlast expected 100 and 7", tag,
                     w_data_q.size(), wlast_cnt);
        end
        bad = -1;
        for (int k = 0; k < w_data_q.size(); k++)
            if (bad < 0 && w_data_q[k] !== pat(k, 1'b0)) bad = k;
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL %s data[%0d]: got %h expected %h", tag, bad, w_data_q[bad],
                     pat(bad, 1'b0));
        end
        tests++;
        if (hold_err !== 0 || zero_err !== 0 || early_err !== 0) begin
            fails++;
            $display("FAIL %s protocol: hold %0d zero %0d early %0d expected 0", tag,
                     hold_err, zero_err, early_err);
        end
    endtask

    task automatic test_reset();
        tests++;
        if ({awvalid, wvalid, wlast, done, awuser_ap, awaddr, awlen, wdata, wstrb} !== '0 ||
            result_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_outputs: got aw %b w %b addr %h data %h rdy %b expected 0s rdy 1",
                     awvalid, wvalid, awaddr, wdata, result_ready);
        end
        tests++;
        if (awuser_id !== 4'h1) begin
            fails++; $display("FAIL awuser_id: got %h expected 1", awuser_id);
        end
    endtask

    task automatic test_basic();
        clear_rec();
        start(28'h000_0100, 1'b1);
        run(1000);
        check_full_run("basic", 28'h000_0100);
    endtask

    task automatic test_wready_toggle();
        clear_rec();
        wr_toggle = 1;
        start(28'h000_0100, 1'b0);
        run(1000);
        check_full_run("toggle", 28'h000_0100);
    endtask

    task automatic test_awready_delay();
        clear_rec();
        aw_delay_burst = 2;
        aw_delay_left  = 5;
        busy_init_on   = 1;
        start(28'h000_0100, 1'b0);
        run(1000);
        check_full_run("awdelay", 28'h000_0100);
        tests++;
        if (aw_delay_left !== 0) begin
            fails++; $display("FAIL awdelay_stall: got %0d left expected 0", aw_delay_left);
        end
    endtask

    task automatic test_busy_ignore();
        clear_rec();
        inject_on = 1;
        start(28'h000_0100, 1'b0);
        run(1000);
        check_full_run("busy", 28'h000_0100);
        tests++;
        if (rr_err !== 0 || injected !== 1'b1) begin
            fails++;
            $display("FAIL busy_ready: got %0d ready-high cycles injected %0d expected 0 and 1",
                     rr_err, injected);
        end
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (awvalid !== 1'b0 || result_ready !== 1'b1) begin
            fails++;
            $display("FAIL busy_requeue: got awvalid %b ready %b expected 0 1", awvalid,
                     result_ready);
        end
    endtask

    task automatic test_mid_reset();
        int dn;
        clear_rec();
        stop_beats = 20;
        start(28'h000_0200, 1'b1);
        run(1000);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({awvalid, wvalid, wlast, done, awuser_ap, awaddr, awlen, wdata, wstrb} !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: got aw %b w %b addr %h data %h expected 0",
                     awvalid, wvalid, awaddr, wdata);
        end
        dn = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        tests++;
        if (dn !== 0 || result_ready !== 1'b1) begin
            fails++;
            $display("FAIL midreset_done: got %0d pulses ready %b expected 0 1", dn,
                     result_ready);
        end
        // Base was cleared by reset, so the fresh run starts at address 0.
        clear_rec();
        start(28'h000_0000, 1'b0);
        run(1000);
        check_full_run("rerun", 28'h000_0000);
    endtask

    task automatic test_single_burst();
        int aw_n, beats, lasts, dn, bad;
        logic [3:0] len;
        logic ap;
        aw_n = 0; beats = 0; lasts = 0; dn = 0; bad = 0; len = '0; ap = 0;
        for (int k = 0; k < NS; k++) s_result[k*32 +: 32] = pat(k, 1'b0);
        @(negedge clk);
        s_result_valid = 1'b1;
        @(negedge clk);
        s_result_valid = 1'b0;
        for (int cyc = 0; cyc < 100 && dn == 0; cyc++) begin
            if (s_awvalid && s_awready) begin aw_n++; len = s_awlen; ap = s_awuser_ap; end
            if (s_wvalid && s_wready) begin
                if (s_wdata !== pat(beats, 1'b0)) bad++;
                beats++;
                if (s_wlast) lasts++;
            end
            if (s_done) dn++;
            @(negedge clk);
        end
        tests++;
        if (aw_n !== 1 || len !== 4'd15 || ap !== 1'b1) begin
            fails++;
            $display("FAIL single_aw: got %0d bursts len %0d ap %b expected 1 15 1", aw_n, len, ap);
        end
        tests++;
        if (beats !== 16 || lasts !== 1 || bad !== 0 || dn !== 1) begin
            fails++;
            $display("FAIL single_w: got %0d beats %0d wlast %0d bad %0d done expected 16 1 0 1",
                     beats, lasts, bad, dn);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        init_addr = '0; init_addr_en = 1'b0; result = '0; result_valid = 1'b0;
        awready = 1'b1; wready = 1'b1;
        s_init_addr = '0; s_init_addr_en = 1'b0; s_result = '0; s_result_valid = 1'b0;
        s_awready = 1'b1; s_wready = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_wready_toggle();
        test_awready_delay();
        test_busy_ignore();
        test_mid_reset();
        test_single_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
